// File: rtl/fp_pkg.sv
// Shared definitions for the floating-point adder front end: alignment FSM
// state encoding, default field widths and derived width helpers.
package fp_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } fp_state_t;

    localparam int EXP_W_DEF = 8;
    localparam int MAN_W_DEF = 23;

    // Aligned mantissa: hidden bit, fraction, then guard/round/sticky.
    function automatic int calc_aw(input int man_w);
        return man_w + 4;
    endfunction

    // Remaining-shift counter must hold any value 0..AW.
    function automatic int calc_cnt_w(input int aw);
        return $clog2(aw + 1);
    endfunction

endpackage

// File: rtl/fp_sticky_shr.sv
// Combinational right shift by 0..SHIFT_STEP; every bit shifted out (and the
// old LSB) is ORed into the new LSB so sticky information is never lost.
module fp_sticky_shr
    import fp_pkg::*;
#(
    parameter int AW         = 27,
    parameter int SHIFT_STEP = 4,
    parameter int SH_W       = $clog2(SHIFT_STEP + 1)
) (
    input  logic [AW-1:0]   i_man,
    input  logic [SH_W-1:0] i_sh,
    output logic [AW-1:0]   o_man
);

    localparam logic [AW-1:0] ONE = {{(AW-1){1'b0}}, 1'b1};

    logic [AW-1:0] w_mask;
    logic [AW-1:0] w_shifted;
    logic          w_lost;

    // Mask selects exactly the bits that fall off the bottom for this shift.
    assign w_mask    = (ONE << i_sh) - ONE;
    assign w_lost    = |(i_man & w_mask);
    assign w_shifted = i_man >> i_sh;
    assign o_man     = {w_shifted[AW-1:1], w_shifted[0] | w_lost};

endmodule

// File: rtl/fp_exp_align.sv
// Exponent compare and mantissa alignment for the FP adder: selects the larger
// magnitude operand and right-shifts the smaller one with sticky tracking.
module fp_exp_align
    import fp_pkg::*;
#(
    parameter int EXP_W      = EXP_W_DEF,
    parameter int MAN_W      = MAN_W_DEF,
    parameter int SHIFT_STEP = 4
) (
    input  logic                   clk,
    input  logic                   res,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [EXP_W+MAN_W:0]   x,
    input  logic [EXP_W+MAN_W:0]   y,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [EXP_W-1:0]       exp_out,
    output logic [MAN_W+3:0]       man_big,
    output logic [MAN_W+3:0]       man_small,
    output logic                   sign_big,
    output logic                   sign_small,
    output logic                   swapped
);

    localparam int AW    = calc_aw(MAN_W);
    localparam int CNT_W = calc_cnt_w(AW);
    localparam int SH_W  = $clog2(SHIFT_STEP + 1);
    localparam int OP_W  = EXP_W + MAN_W + 1;

    function automatic logic [EXP_W-1:0] eff_exp(input logic [EXP_W-1:0] e);
        return (e == '0) ? EXP_W'(1) : e;
    endfunction

    function automatic logic [AW-1:0] load_man(input logic [OP_W-1:0] op);
        return {|op[OP_W-2:MAN_W], op[MAN_W-1:0], 3'b000};
    endfunction

    fp_state_t        r_state;
    logic [CNT_W-1:0] r_rem;
    logic [EXP_W-1:0] r_exp;
    logic [AW-1:0]    r_man_big;
    logic [AW-1:0]    r_man_small;
    logic             r_sign_big;
    logic             r_sign_small;
    logic             r_swapped;
    logic             r_out_valid;

    logic             w_swap;
    logic [OP_W-1:0]  w_big;
    logic [OP_W-1:0]  w_small;
    logic [EXP_W-1:0] w_eff_big;
    logic [EXP_W-1:0] w_eff_small;
    logic [EXP_W-1:0] w_diff;
    logic             w_collapse;
    logic [AW-1:0]    w_man_big;
    logic [AW-1:0]    w_man_small;
    logic [SH_W-1:0]  w_k;
    logic [CNT_W-1:0] w_rem_next;
    logic [AW-1:0]    w_shifted;

    // Magnitude compare ignores the sign; ties keep x as the big operand.
    assign w_swap      = y[OP_W-2:0] > x[OP_W-2:0];
    assign w_big       = w_swap ? y : x;
    assign w_small     = w_swap ? x : y;
    assign w_eff_big   = eff_exp(w_big[OP_W-2:MAN_W]);
    assign w_eff_small = eff_exp(w_small[OP_W-2:MAN_W]);
    assign w_diff      = w_eff_big - w_eff_small;
    assign w_collapse  = 32'(w_diff) >= 32'(AW);
    assign w_man_big   = load_man(w_big);
    assign w_man_small = load_man(w_small);

    always_comb begin
        w_k = SH_W'(r_rem);
        if (32'(r_rem) > 32'(SHIFT_STEP)) begin
            w_k = SH_W'(SHIFT_STEP);
        end
    end

    assign w_rem_next = r_rem - CNT_W'(w_k);

    fp_sticky_shr #(
        .AW         (AW),
        .SHIFT_STEP (SHIFT_STEP),
        .SH_W       (SH_W)
    ) u_shr (
        .i_man (r_man_small),
        .i_sh  (w_k),
        .o_man (w_shifted)
    );

    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            r_state      <= ST_IDLE;
            r_rem        <= '0;
            r_exp        <= '0;
            r_man_big    <= '0;
            r_man_small  <= '0;
            r_sign_big   <= 1'b0;
            r_sign_small <= 1'b0;
            r_swapped    <= 1'b0;
            r_out_valid  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (in_valid) begin
                        r_exp        <= w_eff_big;
                        r_man_big    <= w_man_big;
                        r_sign_big   <= w_big[OP_W-1];
                        r_sign_small <= w_small[OP_W-1];
                        r_swapped    <= w_swap;
                        if (w_diff == '0) begin
                            r_man_small <= w_man_small;
                            r_out_valid <= 1'b1;
                            r_state     <= ST_DONE;
                        end else if (w_collapse) begin
                            // Everything shifts out; only the sticky survives.
                            r_man_small <= {{(AW-1){1'b0}}, |w_man_small};
                            r_out_valid <= 1'b1;
                            r_state     <= ST_DONE;
                        end else begin
                            r_man_small <= w_man_small;
                            r_rem       <= CNT_W'(w_diff);
                            r_state     <= ST_SHIFT;
                        end
                    end
                end
                ST_SHIFT: begin
                    r_man_small <= w_shifted;
                    r_rem       <= w_rem_next;
                    if (w_rem_next == '0) begin
                        r_out_valid <= 1'b1;
                        r_state     <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_state     <= ST_IDLE;
                    end
                end
                default: begin
                    r_out_valid <= 1'b0;
                    r_state     <= ST_IDLE;
                end
            endcase
        end
    end

    assign in_ready   = (r_state == ST_IDLE);
    assign out_valid  = r_out_valid;
    assign exp_out    = r_exp;
    assign man_big    = r_man_big;
    assign man_small  = r_man_small;
    assign sign_big   = r_sign_big;
    assign sign_small = r_sign_small;
    assign swapped    = r_swapped;

endmodule
